// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with a per-grant hold limit and a one-cycle
// break-before-make gap between grants; all outputs are registered.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_en,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_r, state_s;
  logic [2:0] idx_r, idx_s;
  logic [2:0] last_r, last_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] grant_r, grant_s;
  logic       en_r, en_s;
  logic       tmo_r, tmo_s;
  logic [2:0] base_s;
  logic [3:0] pick_s;

  // First set request strictly after 'last', wrapping 7 -> 0; bit 3 = found.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'd0;
    for (int i = 8; i >= 1; i--) begin
      k = last + 3'(i);
      if (r[k]) begin
        res = {1'b1, k};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    en_s    = 1'b0;
    tmo_s   = 1'b0;
    // Leaving GAP the grantee becomes 'last', so GAP arbitrates from idx_r
    // directly and a pending request is granted without an extra dead cycle.
    if (state_r == GAP) begin
      base_s = idx_r;
    end else begin
      base_s = last_r;
    end
    pick_s = rr_pick(req, base_s);

    case (state_r)
      IDLE, GAP: begin
        if (state_r == GAP) begin
          last_s = idx_r;
        end else begin
          last_s = last_r;
        end
        if (pick_s[3]) begin
          idx_s   = pick_s[2:0];
          cnt_s   = 8'd0;
          en_s    = 1'b1;
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!req[idx_r]) begin
          state_s = GAP;
        end else if (cnt_r == HOLD_LAST) begin
          state_s = GAP;
          tmo_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
          en_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (en_s) begin
      grant_s = 8'd1 << idx_s;
    end else begin
      grant_s = 8'd0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 3'd0;
      last_r  <= 3'd7;
      cnt_r   <= 8'd0;
      grant_r <= 8'd0;
      en_r    <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      grant_r <= grant_s;
      en_r    <= en_s;
      tmo_r   <= tmo_s;
    end
  end

  assign grant     = grant_r;
  assign grant_idx = idx_r;
  assign grant_en  = en_r;
  assign timeout   = tmo_r;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (default MAX_HOLD and MAX_HOLD=4).
module tb_rr_decode_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant, grant4;
  logic [2:0] grant_idx, grant_idx4;
  logic       grant_en, grant_en4;
  logic       timeout, timeout4;

  int passed;
  int total;

  rr_decode_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_en(grant_en), .timeout(timeout)
  );

  rr_decode_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant4), .grant_idx(grant_idx4), .grant_en(grant_en4), .timeout(timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    total++;
    if ({grant, grant_idx, grant_en, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_outputs: got %h/%0d/%b/%b expected 00/0/0/0", grant, grant_idx, grant_en, timeout);
    end else passed++;
    rst = 1'b0;
    tick();
    total++;
    if ({grant, grant_en} !== {8'h00, 1'b0}) begin
      $display("FAIL idle_no_req: got %h/%b expected 00/0", grant, grant_en);
    end else passed++;
  endtask

  task automatic test_timeout();
    req = 8'h01;
    tick();
    total++;
    if ({grant, grant_idx, grant_en, timeout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      $display("FAIL first_grant: got %h/%0d/%b/%b expected 01/0/1/0", grant, grant_idx, grant_en, timeout);
    end else passed++;
    for (int i = 2; i <= 15; i++) begin
      tick();
      total++;
      if ({grant, grant_en, timeout} !== {8'h01, 1'b1, 1'b0}) begin
        $display("FAIL hold_cycle_%0d: got %h/%b/%b expected 01/1/0", i, grant, grant_en, timeout);
      end else passed++;
    end
    tick();
    total++;
    if ({grant, grant_idx, grant_en, timeout} !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
      $display("FAIL timeout_gap: got %h/%0d/%b/%b expected 00/0/0/1", grant, grant_idx, grant_en, timeout);
    end else passed++;
    tick();
    total++;
    if ({grant, grant_en, timeout} !== {8'h01, 1'b1, 1'b0}) begin
      $display("FAIL regrant_single: got %h/%b/%b expected 01/1/0", grant, grant_en, timeout);
    end else passed++;
    req = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    do_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      e = 3'(n % 8);
      tick();
      total++;
      if ({grant, grant_idx, grant_en} !== {8'd1 << e, e, 1'b1}) begin
        $display("FAIL rr_grant_%0d: got %h/%0d expected %h/%0d", n, grant, grant_idx, 8'd1 << e, e);
      end else passed++;
      tick();
      total++;
      if (grant !== (8'd1 << e)) begin
        $display("FAIL rr_hold_%0d: got %h expected %h", n, grant, 8'd1 << e);
      end else passed++;
      req[e] = 1'b0;
      tick();
      total++;
      if ({grant, grant_en, timeout} !== {8'h00, 1'b0, 1'b0}) begin
        $display("FAIL rr_gap_%0d: got %h/%b/%b expected 00/0/0", n, grant, grant_en, timeout);
      end else passed++;
      req = 8'hFF;
    end
    req = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h88;
    tick();
    total++;
    if ({grant, grant_idx} !== {8'h08, 3'd3}) begin
      $display("FAIL wrap_idx3: got %h/%0d expected 08/3", grant, grant_idx);
    end else passed++;
    req = 8'h80;
    tick();
    total++;
    if ({grant, grant_en} !== {8'h00, 1'b0}) begin
      $display("FAIL wrap_gap1: got %h/%b expected 00/0", grant, grant_en);
    end else passed++;
    tick();
    total++;
    if ({grant, grant_idx} !== {8'h80, 3'd7}) begin
      $display("FAIL wrap_idx7: got %h/%0d expected 80/7", grant, grant_idx);
    end else passed++;
    req = 8'h09;
    tick();
    total++;
    if ({grant, grant_idx, grant_en} !== {8'h00, 3'd7, 1'b0}) begin
      $display("FAIL wrap_gap2: got %h/%0d/%b expected 00/7/0", grant, grant_idx, grant_en);
    end else passed++;
    tick();
    total++;
    if ({grant, grant_idx} !== {8'h01, 3'd0}) begin
      $display("FAIL wrap_to_0: got %h/%0d expected 01/0", grant, grant_idx);
    end else passed++;
    req = 8'h00;
    tick();
    tick();
    total++;
    if ({grant, grant_idx, grant_en} !== {8'h00, 3'd0, 1'b0}) begin
      $display("FAIL idx_held_idle: got %h/%0d/%b expected 00/0/0", grant, grant_idx, grant_en);
    end else passed++;
    tick();
  endtask

  task automatic test_maxhold4();
    do_reset();
    req = 8'h24;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if ({grant4, grant_idx4, grant_en4, timeout4} !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
        $display("FAIL mh4_hold_%0d: got %h/%0d/%b/%b expected 04/2/1/0", i, grant4, grant_idx4, grant_en4, timeout4);
      end else passed++;
    end
    tick();
    total++;
    if ({grant4, grant_en4, timeout4} !== {8'h00, 1'b0, 1'b1}) begin
      $display("FAIL mh4_timeout: got %h/%b/%b expected 00/0/1", grant4, grant_en4, timeout4);
    end else passed++;
    tick();
    total++;
    if ({grant4, grant_idx4, timeout4} !== {8'h20, 3'd5, 1'b0}) begin
      $display("FAIL mh4_idx5: got %h/%0d/%b expected 20/5/0", grant4, grant_idx4, timeout4);
    end else passed++;
    req = 8'h04;
    tick();
    total++;
    if ({grant4, timeout4} !== {8'h00, 1'b0}) begin
      $display("FAIL mh4_release_gap: got %h/%b expected 00/0", grant4, timeout4);
    end else passed++;
    tick();
    total++;
    if ({grant4, grant_idx4} !== {8'h04, 3'd2}) begin
      $display("FAIL mh4_regrant2: got %h/%0d expected 04/2", grant4, grant_idx4);
    end else passed++;
  endtask

  task automatic test_drop_at_limit();
    for (int i = 2; i <= 4; i++) begin
      tick();
      total++;
      if (grant4 !== 8'h04) begin
        $display("FAIL limit_hold_%0d: got %h expected 04", i, grant4);
      end else passed++;
    end
    req = 8'h00;
    tick();
    total++;
    if ({grant4, grant_en4, timeout4} !== {8'h00, 1'b0, 1'b0}) begin
      $display("FAIL limit_drop_no_timeout: got %h/%b/%b expected 00/0/0", grant4, grant_en4, timeout4);
    end else passed++;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h40;
    tick();
    total++;
    if ({grant, grant_idx} !== {8'h40, 3'd6}) begin
      $display("FAIL ar_idx6: got %h/%0d expected 40/6", grant, grant_idx);
    end else passed++;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({grant, grant_en, grant_idx} !== {8'h00, 1'b0, 3'd0}) begin
      $display("FAIL ar_async_drop: got %h/%b/%0d expected 00/0/0", grant, grant_en, grant_idx);
    end else passed++;
    req = 8'h50;
    #2;
    rst = 1'b0;
    tick();
    total++;
    if ({grant, grant_idx} !== {8'h10, 3'd4}) begin
      $display("FAIL ar_first_after: got %h/%0d expected 10/4", grant, grant_idx);
    end else passed++;
    req = 8'h00;
    repeat (3) tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    req    = 8'h00;
    test_reset();
    test_timeout();
    test_round_robin();
    test_wrap();
    test_maxhold4();
    test_drop_at_limit();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
